range_ctrl: RTL and testbench

//  Command sequencer for the range (Collatz iteration-count) engine. Turns the four pushbuttons

---
 rtl/range_ctrl_pkg.sv | 39 +++
 rtl/range_if.sv | 10 +
 rtl/range_ctrl_key_debounce.sv | 50 +++++
 rtl/range_ctrl.sv | 171 +++++++++++++++++
 tb/tb_range_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/range_ctrl_pkg.sv
// Shared types and constants for the range command sequencer.
package range_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        SHOW = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_GO   = 3'd1,
        CMD_HOME = 3'd2,
        CMD_INC  = 3'd3,
        CMD_DEC  = 3'd4
    } cmd_t;

    localparam int KEY_GO   = 3;
    localparam int KEY_HOME = 2;
    localparam int KEY_DEC  = 1;
    localparam int KEY_INC  = 0;

    // Same-cycle presses resolve go > home > inc > dec; the losers are dropped.
    function automatic cmd_t pick_cmd(input logic [3:0] press);
        cmd_t c;
        c = CMD_NONE;
        if (press[KEY_GO])
            c = CMD_GO;
        else if (press[KEY_HOME])
            c = CMD_HOME;
        else if (press[KEY_INC])
            c = CMD_INC;
        else if (press[KEY_DEC])
            c = CMD_DEC;
        return c;
    endfunction

endpackage

// File: rtl/range_if.sv
// Handshake and RAM read-back bus between the sequencer and the range engine.
interface range_if;
    logic        go;
    logic [31:0] start;
    logic        done;
    logic [15:0] count;

    modport master (output go, output start, input done, input count);
    modport slave  (input go, input start, output done, output count);
endinterface

// File: rtl/range_ctrl_key_debounce.sv
// One pushbutton: 2-flop synchroniser, stable-low down-counter, single press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_BITS         = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);
    localparam logic [DB_BITS-1:0] DB_LOAD = DB_BITS'(DEBOUNCE_CYCLES - 1);

    logic                sync_a;
    logic                sync_b;
    logic                armed;
    logic [DB_BITS-1:0]  db_cnt;

    // Bring the asynchronous key into the clk domain; idle level is released (high).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    // Count consecutive low samples; fire once at terminal count, re-arm only on release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt <= '0;
            armed  <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_b) begin
                db_cnt <= DB_LOAD;
                armed  <= 1'b1;
            end else if (armed) begin
                if (db_cnt == '0) begin
                    press <= 1'b1;
                    armed <= 1'b0;
                end else begin
                    db_cnt <= db_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/range_ctrl.sv
// Range engine command sequencer: debounced keys -> go/start handshake -> RAM read-back.
//
// state | meaning
// IDLE  | nothing run since reset; only go is accepted
// RUN   | engine running, waiting for done
// WAIT  | read address applied, waiting out the RAM latency
// SHOW  | disp_count valid; go/home/inc/dec accepted
module range_ctrl
    import range_ctrl_pkg::*;
#(
    parameter int RAM_WORDS       = 256,
    parameter int RAM_ADDR_BITS   = 8,
    parameter int READ_LAT        = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_BITS         = 20
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    key_n,
    input  logic [9:0]    sw,
    range_if.master       rng,
    output logic [15:0]   disp_n,
    output logic [15:0]   disp_count,
    output logic          count_valid,
    output logic          busy
);
    localparam int WC_BITS = $clog2(READ_LAT + 1);
    localparam logic [RAM_ADDR_BITS-1:0] OFF_MAX = RAM_ADDR_BITS'(RAM_WORDS - 1);

    logic [3:0] press;
    cmd_t       cmd;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_BITS         (DB_BITS)
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .key_n   (key_n[k]),
            .press   (press[k])
        );
    end

    assign cmd = pick_cmd(press);

    state_t                   state_q, state_d;
    logic [9:0]               base_q, base_d;
    logic [RAM_ADDR_BITS-1:0] offset_q, offset_d;
    logic [31:0]              start_q, start_d;
    logic                     go_q, go_d;
    logic [15:0]              disp_n_q, disp_n_d;
    logic [15:0]              disp_count_q, disp_count_d;
    logic                     valid_q, valid_d;
    logic                     busy_d;
    logic [WC_BITS-1:0]       wait_q, wait_d;

    // Register all sequencer state and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            offset_q     <= '0;
            start_q      <= '0;
            go_q         <= 1'b0;
            disp_n_q     <= '0;
            disp_count_q <= '0;
            valid_q      <= 1'b0;
            busy         <= 1'b0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            offset_q     <= offset_d;
            start_q      <= start_d;
            go_q         <= go_d;
            disp_n_q     <= disp_n_d;
            disp_count_q <= disp_count_d;
            valid_q      <= valid_d;
            busy         <= busy_d;
            wait_q       <= wait_d;
        end
    end

    // Next-state and next-output logic; an offset change always re-reads the RAM.
    always_comb begin
        logic                     reread;
        logic [RAM_ADDR_BITS-1:0] new_off;

        state_d      = state_q;
        base_d       = base_q;
        offset_d     = offset_q;
        start_d      = start_q;
        go_d         = 1'b0;
        disp_n_d     = disp_n_q;
        disp_count_d = disp_count_q;
        valid_d      = valid_q;
        wait_d       = wait_q;
        reread       = 1'b0;
        new_off      = offset_q;

        unique case (state_q)
            IDLE, SHOW: begin
                if (cmd == CMD_GO) begin
                    base_d   = sw;
                    start_d  = {22'd0, sw};
                    go_d     = 1'b1;
                    offset_d = '0;
                    disp_n_d = {6'd0, sw};
                    valid_d  = 1'b0;
                    state_d  = RUN;
                end else if (state_q == SHOW) begin
                    unique case (cmd)
                        CMD_HOME: begin
                            new_off = '0;
                            reread  = 1'b1;
                        end
                        CMD_INC: begin
                            if (offset_q != OFF_MAX) begin
                                new_off = offset_q + 1'b1;
                                reread  = 1'b1;
                            end
                        end
                        CMD_DEC: begin
                            if (offset_q != '0) begin
                                new_off = offset_q - 1'b1;
                                reread  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (rng.done) begin
                    start_d = {{(32-RAM_ADDR_BITS){1'b0}}, offset_q};
                    wait_d  = WC_BITS'(READ_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Down-counter loaded with READ_LAT: capture lands READ_LAT+1 cycles after the address.
                if (wait_q == '0) begin
                    disp_count_d = rng.count;
                    valid_d      = 1'b1;
                    state_d      = SHOW;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reread) begin
            offset_d = new_off;
            start_d  = {{(32-RAM_ADDR_BITS){1'b0}}, new_off};
            disp_n_d = {6'd0, base_q} + {{(16-RAM_ADDR_BITS){1'b0}}, new_off};
            valid_d  = 1'b0;
            wait_d   = WC_BITS'(READ_LAT);
            state_d  = WAIT;
        end

        busy_d = (state_d == RUN) || (state_d == WAIT);
    end

    assign rng.go      = go_q;
    assign rng.start   = start_q;
    assign disp_n      = disp_n_q;
    assign disp_count  = disp_count_q;
    assign count_valid = valid_q;
endmodule

// File: tb/tb_range_ctrl.sv
// Directed bench for range_ctrl with a latency-accurate range engine model.
module tb_range_ctrl;
    import range_ctrl_pkg::*;

    localparam int READ_LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  key_n = 4'hF;
    logic [9:0]  sw = '0;
    logic [15:0] disp_n;
    logic [15:0] disp_count;
    logic        count_valid;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int n_go = 0;
    int n_fall = 0;

    range_if rng();

    range_ctrl #(
        .RAM_WORDS       (256),
        .RAM_ADDR_BITS   (8),
        .READ_LAT        (READ_LAT),
        .DEBOUNCE_CYCLES (4),
        .DB_BITS         (20)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_n       (key_n),
        .sw          (sw),
        .rng         (rng),
        .disp_n      (disp_n),
        .disp_count  (disp_count),
        .count_valid (count_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic int steps(input int n);
        longint v;
        int s;
        v = longint'(n);
        s = 0;
        if (n < 1) return 0;
        while (v != 1 && s < 2000) begin
            if (v[0]) v = 3 * v + 1;
            else      v = v >> 1;
            s++;
        end
        return s;
    endfunction

    // Engine model: base captured on go, RAM read data READ_LAT cycles after the address.
    logic [9:0] base_m = '0;
    logic [7:0] a1 = '0;
    logic [7:0] a2 = '0;
    always @(posedge clk) begin
        if (rng.go) base_m <= rng.start[9:0];
        a1 <= rng.start[7:0];
        a2 <= a1;
        rng.count <= 16'(steps(int'(base_m) + int'(a2)));
    end

    always @(posedge clk) if (rng.go === 1'b1) n_go++;
    always @(negedge count_valid) n_fall++;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (count_valid) break;
            tick();
        end
        check(tag, 32'(count_valid), 32'd1);
    endtask

    task automatic press(input int k, input int low);
        key_n[k] = 1'b0;
        repeat (low) tick();
        key_n[k] = 1'b1;
        repeat (3) tick();
    endtask

    task automatic wait_go(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rng.go) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic do_go(input logic [9:0] v, input int run_cycles);
        sw = v;
        key_n[KEY_GO] = 1'b0;
        wait_go("go_seen");
        check("go_start", rng.start, 32'(v));
        tick();
        check("go_one_cycle", 32'(rng.go), 32'd0);
        key_n[KEY_GO] = 1'b1;
        repeat (run_cycles) tick();
        rng.done = 1'b1;
        wait_valid("run_valid");
        rng.done = 1'b0;
        check("run_disp_n", 32'(disp_n), 32'(v));
    endtask

    initial begin
        int g0;
        int f0;
        int lat;
        bit found;

        rng.done = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_go", 32'(rng.go), 32'd0);
        check("rst_start", rng.start, 32'd0);
        check("rst_disp_n", 32'(disp_n), 32'd0);
        check("rst_disp_count", 32'(disp_count), 32'd0);
        check("rst_valid", 32'(count_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: go with base 27, done after 50 cycles, latency of the read-back
        g0 = n_go;
        sw = 10'd27;
        key_n[KEY_GO] = 1'b0;
        wait_go("t1_go");
        check("t1_start", rng.start, 32'd27);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_disp_n", 32'(disp_n), 32'd27);
        check("t1_valid0", 32'(count_valid), 32'd0);
        tick();
        check("t1_go_low", 32'(rng.go), 32'd0);
        key_n[KEY_GO] = 1'b1;
        repeat (48) tick();
        rng.done = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rng.start == 32'd0) begin
                found = 1'b1;
                break;
            end
        end
        check("t1_start_addr", 32'(found), 32'd1);
        lat = 0;
        while (!count_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("t1_latency", 32'(lat), 32'(READ_LAT + 1));
        check("t1_disp_count", 32'(disp_count), 32'h6F);
        check("t1_disp_n2", 32'(disp_n), 32'd27);
        check("t1_busy0", 32'(busy), 32'd0);
        check("t1_go_count", 32'(n_go - g0), 32'd1);
        rng.done = 1'b0;

        // 2: inc x3, dec x4 with the last dec saturating at 0
        for (int i = 0; i < 3; i++) begin
            press(KEY_INC, 10);
            wait_valid("t2_inc_valid");
        end
        check("t2_start3", rng.start, 32'd3);
        check("t2_disp_n30", 32'(disp_n), 32'd30);
        check("t2_count30", 32'(disp_count), 32'd18);
        for (int i = 0; i < 3; i++) begin
            press(KEY_DEC, 10);
            wait_valid("t2_dec_valid");
        end
        f0 = n_fall;
        press(KEY_DEC, 10);
        repeat (10) tick();
        check("t2_dec_ignored", 32'(n_fall - f0), 32'd0);
        check("t2_start0", rng.start, 32'd0);
        check("t2_disp_n27", 32'(disp_n), 32'd27);
        check("t2_count27", 32'(disp_count), 32'd111);

        // 3: base 1000, inc to offset 255, saturation, home
        do_go(10'd1000, 20);
        for (int i = 0; i < 255; i++) begin
            press(KEY_INC, 10);
            wait_valid("t3_inc_valid");
        end
        check("t3_disp_n1255", 32'(disp_n), 32'd1255);
        check("t3_start255", rng.start, 32'd255);
        check("t3_count1255", 32'(disp_count), 32'(steps(1255)));
        f0 = n_fall;
        press(KEY_INC, 10);
        repeat (10) tick();
        check("t3_inc_sat", 32'(n_fall - f0), 32'd0);
        check("t3_disp_n_sat", 32'(disp_n), 32'd1255);
        press(KEY_HOME, 10);
        wait_valid("t3_home_valid");
        check("t3_home_disp_n", 32'(disp_n), 32'd1000);
        check("t3_home_start", rng.start, 32'd0);

        // 4: go beats inc on the same cycle; inc in RUN and WAIT is ignored
        press(KEY_INC, 10);
        wait_valid("t4_inc_valid");
        check("t4_disp_n1001", 32'(disp_n), 32'd1001);
        sw = 10'd5;
        key_n[KEY_GO]  = 1'b0;
        key_n[KEY_INC] = 1'b0;
        wait_go("t4_go");
        check("t4_go_start", rng.start, 32'd5);
        check("t4_go_disp_n", 32'(disp_n), 32'd5);
        key_n[KEY_GO]  = 1'b1;
        key_n[KEY_INC] = 1'b1;
        repeat (3) tick();
        press(KEY_INC, 10);
        check("t4_run_busy", 32'(busy), 32'd1);
        check("t4_run_start", rng.start, 32'd5);
        check("t4_run_valid", 32'(count_valid), 32'd0);
        key_n[KEY_INC] = 1'b0;
        repeat (4) tick();
        rng.done = 1'b1;
        repeat (7) tick();
        key_n[KEY_INC] = 1'b1;
        wait_valid("t4_wait_valid");
        rng.done = 1'b0;
        repeat (3) tick();
        check("t4_start0", rng.start, 32'd0);
        check("t4_disp_n5", 32'(disp_n), 32'd5);
        check("t4_count5", 32'(disp_count), 32'd5);

        // 5: a 3-cycle bounce does nothing; a 40-cycle hold gives one command
        f0 = n_fall;
        key_n[KEY_HOME] = 1'b0;
        repeat (3) tick();
        key_n[KEY_HOME] = 1'b1;
        repeat (12) tick();
        check("t5_bounce", 32'(n_fall - f0), 32'd0);
        f0 = n_fall;
        key_n[KEY_HOME] = 1'b0;
        repeat (40) tick();
        key_n[KEY_HOME] = 1'b1;
        repeat (5) tick();
        wait_valid("t5_hold_valid");
        check("t5_hold_once", 32'(n_fall - f0), 32'd1);
        check("t5_disp_n", 32'(disp_n), 32'd5);

        // 6: asynchronous reset in RUN, done held across release
        sw = 10'd100;
        key_n[KEY_GO] = 1'b0;
        wait_go("t6_go_run");
        key_n[KEY_GO] = 1'b1;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        check("t6r_start", rng.start, 32'd0);
        check("t6r_disp_n", 32'(disp_n), 32'd0);
        check("t6r_busy", 32'(busy), 32'd0);
        check("t6r_go", 32'(rng.go), 32'd0);
        check("t6r_valid", 32'(count_valid), 32'd0);
        check("t6r_disp_count", 32'(disp_count), 32'd0);
        rng.done = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        g0 = n_go;
        repeat (20) tick();
        check("t6_idle_no_go", 32'(n_go - g0), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_valid", 32'(count_valid), 32'd0);
        rng.done = 1'b0;

        // 6: asynchronous reset in WAIT
        sw = 10'd200;
        key_n[KEY_GO] = 1'b0;
        wait_go("t6_go_wait");
        key_n[KEY_GO] = 1'b1;
        repeat (5) tick();
        rng.done = 1'b1;
        tick();
        check("t6w_busy", 32'(busy), 32'd1);
        check("t6w_disp_n", 32'(disp_n), 32'd200);
        #2 reset_n = 1'b0;
        #1;
        check("t6w_r_disp_n", 32'(disp_n), 32'd0);
        check("t6w_r_busy", 32'(busy), 32'd0);
        check("t6w_r_valid", 32'(count_valid), 32'd0);
        rng.done = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
